// File: rtl/vehicle_sensor_conditioner.sv
// Two-channel inductive-loop conditioner: synchroniser, debounce, presence hold,
// saturating vehicle counter and stuck-loop detection with fail-safe demand.
module vehicle_sensor_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int HOLD_CYCLES  = 10,
    parameter int STUCK_CYCLES = 200,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             main_loop_raw,
    input  logic             side_loop_raw,
    input  logic             count_clr,
    output logic             main_sensor,
    output logic             side_sensor,
    output logic [CNT_W-1:0] main_count,
    output logic [CNT_W-1:0] side_count,
    output logic             main_fault,
    output logic             side_fault
);

    // One shared run counter per channel covers debounce, hold and stuck timing.
    localparam int MAX_AB  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int MAX_RUN = (MAX_AB > STUCK_CYCLES) ? MAX_AB : STUCK_CYCLES;
    localparam int RUN_W   = $clog2(MAX_RUN + 1);

    localparam logic [RUN_W-1:0] DB_TC    = RUN_W'(DB_CYCLES);
    localparam logic [RUN_W-1:0] HOLD_TC  = RUN_W'(HOLD_CYCLES);
    localparam logic [RUN_W-1:0] STUCK_TC = RUN_W'(STUCK_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_PRESENT,
        ST_HOLD,
        ST_FAULT
    } state_t;

    logic [1:0]       w_raw;
    logic [1:0]       w_sensor;
    logic [1:0]       w_fault;
    logic [CNT_W-1:0] w_count [2];

    assign w_raw = {side_loop_raw, main_loop_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t           r_state;
        logic             r_ff1;
        logic             r_ff2;
        logic [RUN_W-1:0] r_run;
        logic             r_sensor;
        logic             r_fault;
        logic [CNT_W-1:0] r_count;
        logic             w_s;
        logic [RUN_W-1:0] w_run_inc;
        logic             w_qualified;

        assign w_s         = r_ff2;
        assign w_run_inc   = r_run + RUN_W'(1);
        assign w_qualified = w_s && (((r_state == ST_IDLE) && (DB_CYCLES == 1)) ||
                                     ((r_state == ST_QUALIFY) && (w_run_inc == DB_TC)));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ff1    <= 1'b0;
                r_ff2    <= 1'b0;
                r_state  <= ST_IDLE;
                r_run    <= '0;
                r_sensor <= 1'b0;
                r_fault  <= 1'b0;
                r_count  <= '0;
            end else begin
                r_ff1 <= w_raw[ch];
                r_ff2 <= r_ff1;

                // Clear takes priority over a same-edge qualification.
                if (count_clr) begin
                    r_count <= '0;
                end else if (w_qualified && (r_count != '1)) begin
                    r_count <= r_count + CNT_W'(1);
                end

                case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            if (DB_CYCLES == 1) begin
                                r_state  <= ST_PRESENT;
                                r_run    <= '0;
                                r_sensor <= 1'b1;
                            end else begin
                                r_state <= ST_QUALIFY;
                                r_run   <= RUN_W'(1);
                            end
                        end
                    end
                    ST_QUALIFY: begin
                        if (!w_s) begin
                            r_state <= ST_IDLE;
                            r_run   <= '0;
                        end else if (w_run_inc == DB_TC) begin
                            r_state  <= ST_PRESENT;
                            r_run    <= '0;
                            r_sensor <= 1'b1;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    ST_PRESENT: begin
                        if (!w_s) begin
                            if (HOLD_CYCLES == 1) begin
                                r_state  <= ST_IDLE;
                                r_run    <= '0;
                                r_sensor <= 1'b0;
                            end else begin
                                r_state <= ST_HOLD;
                                r_run   <= RUN_W'(1);
                            end
                        end else if (w_run_inc == STUCK_TC) begin
                            r_state <= ST_FAULT;
                            r_run   <= '0;
                            r_fault <= 1'b1;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    ST_HOLD: begin
                        if (w_s) begin
                            r_state <= ST_PRESENT;
                            r_run   <= '0;
                        end else if (w_run_inc == HOLD_TC) begin
                            r_state  <= ST_IDLE;
                            r_run    <= '0;
                            r_sensor <= 1'b0;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    ST_FAULT: begin
                        // Demand stays forced high until the loop reads clean-low again.
                        if (w_s) begin
                            r_run <= '0;
                        end else if (w_run_inc == DB_TC) begin
                            r_state  <= ST_IDLE;
                            r_run    <= '0;
                            r_sensor <= 1'b0;
                            r_fault  <= 1'b0;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_run    <= '0;
                        r_sensor <= 1'b0;
                        r_fault  <= 1'b0;
                    end
                endcase
            end
        end

        assign w_sensor[ch] = r_sensor;
        assign w_fault[ch]  = r_fault;
        assign w_count[ch]  = r_count;
    end

    assign main_sensor = w_sensor[0];
    assign side_sensor = w_sensor[1];
    assign main_fault  = w_fault[0];
    assign side_fault  = w_fault[1];
    assign main_count  = w_count[0];
    assign side_count  = w_count[1];

endmodule
